// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
//
// Purpose: state encoding, WB bubble value and default memory timeout used by
//          pipe_ctrl and its helpers.
// Ports:   none (package).
// Config:  PIPE_CTRL_PERF_EN is consumed by pipe_ctrl, not here.

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pipe_state_e;

  // WB control value that turns the MEM/WB slot into a no-op.
  localparam logic [1:0] WB_BUBBLE = 2'b00;

  localparam int DEF_MEM_TIMEOUT = 15;

  // Next WB control for the MEM/WB register: the bubble value when the slot
  // must not retire, otherwise the control coming from EX/MEM.
  function automatic logic [1:0] wb_ctrl_next(input logic bubble, input logic [1:0] wb_in);
    return bubble ? WB_BUBBLE : wb_in;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - control/handshake bundle between the pipeline and pipe_ctrl
//
// Purpose: groups every hazard input, pipeline-register control output,
//          data-memory request/ready pair, error flag and perf counter.
// Modports:
//   slave  - used by pipe_ctrl: hazard/memory status in, controls out.
//   master - used by the pipeline side (or a bench): drives status, observes controls.

interface pipe_ctrl_if;

  // Hazard / memory status from the datapath.
  logic        MemRead_ex;
  logic [4:0]  rdAddr_ex;
  logic [4:0]  rs1Addr_id;
  logic [4:0]  rs2Addr_id;
  logic        rs1Used_id;
  logic        rs2Used_id;
  logic        BranchTaken_ex;
  logic        MemAccess_mem;
  logic        dmem_ready;

  // Controls towards the pipeline registers and data memory.
  logic        dmem_req;
  logic        PCWrite;
  logic        IFID_en;
  logic        IDEX_en;
  logic        EXMEM_en;
  logic        IFID_flush;
  logic        IDEX_flush;
  logic        MEMWB_bubble;
  logic        mem_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport slave (
    input  MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, dmem_ready,
    output dmem_req, PCWrite, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush,
           MEMWB_bubble, mem_err, stall_cnt, flush_cnt
  );

  modport master (
    output MemRead_ex, rdAddr_ex, rs1Addr_id, rs2Addr_id, rs1Used_id, rs2Used_id,
           BranchTaken_ex, MemAccess_mem, dmem_ready,
    input  dmem_req, PCWrite, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush,
           MEMWB_bubble, mem_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_detect.sv
// rtl/pipe_hazard_detect.sv - combinational load-use hazard comparator
//
// Purpose: flags when the instruction in ID reads the register a load in EX
//          is about to write. x0 is never a hazard.
// Ports:
//   mem_read_i          in  EX instruction is a load
//   rd_addr_i           in  EX destination register
//   rs1_addr_i/rs2_addr_i in ID source registers
//   rs1_used_i/rs2_used_i in ID instruction actually reads rs1/rs2
//   hazard_o            out load-use hazard present

module pipe_hazard_detect (
  input  logic       mem_read_i,
  input  logic [4:0] rd_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  output logic       hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = rs1_used_i && (rs1_addr_i == rd_addr_i);
  assign rs2_hit  = rs2_used_i && (rs2_addr_i == rd_addr_i);
  assign hazard_o = mem_read_i && (rd_addr_i != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush sequencer for the five-stage core
//
// Purpose: owns every freeze and bubble decision for IF/ID, ID/EX, EX/MEM,
//          MEM/WB and the PC. Priority: memory stall > taken branch > load-use.
//          Controls are Mealy (same-cycle); state, wait counter, mem_err and
//          perf counters are registered.
// Ports:
//   clk    in  core clock
//   rst_n  in  asynchronous active-low reset
//   pif    pipe_ctrl_if.slave (hazard/memory status in, controls out)
// Params:
//   MEM_TIMEOUT  consecutive stalled MEM_WAIT cycles before entering ERR
// Config:
//   PIPE_CTRL_PERF_EN  builds stall_cnt/flush_cnt; otherwise both read 0.

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  pif
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(MEM_TIMEOUT);

  pipe_state_e   state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;

  logic          load_use;
  logic          mem_stall;
  logic [CW-1:0] wcnt_inc;

  logic pc_write, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, memwb_bubble, dmem_req;

  pipe_hazard_detect u_hazard (
    .mem_read_i (pif.MemRead_ex),
    .rd_addr_i  (pif.rdAddr_ex),
    .rs1_addr_i (pif.rs1Addr_id),
    .rs2_addr_i (pif.rs2Addr_id),
    .rs1_used_i (pif.rs1Used_id),
    .rs2_used_i (pif.rs2Used_id),
    .hazard_o   (load_use)
  );

  assign mem_stall = pif.MemAccess_mem && !pif.dmem_ready;

  // Saturating so the counter can never wrap back below the timeout.
  assign wcnt_inc = (wcnt_q == TIMEOUT_VAL) ? wcnt_q : wcnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    err_d        = err_q;
    pc_write     = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    dmem_req     = 1'b0;

    if (state_q == ERR) begin
      // Dead pipeline: nothing moves, nothing retires, no memory traffic.
      pc_write     = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else begin
      dmem_req = pif.MemAccess_mem;
      if (mem_stall) begin
        pc_write     = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        if (state_q == RUN) begin
          state_d = MEM_WAIT;
          wcnt_d  = '0;
        end else begin
          // The incremented value is this cycle's ordinal, so the
          // MEM_TIMEOUT-th stalled wait cycle is the one that gives up.
          wcnt_d = wcnt_inc;
          if (wcnt_inc == TIMEOUT_VAL) begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end else begin
        // Pipeline advances this cycle (including the MEM_WAIT release
        // cycle), so branch and load-use get evaluated again.
        state_d = RUN;
        wcnt_d  = '0;
        if (pif.BranchTaken_ex) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
    end
  end

  assign pif.dmem_req     = dmem_req;
  assign pif.PCWrite      = pc_write;
  assign pif.IFID_en      = ifid_en;
  assign pif.IDEX_en      = idex_en;
  assign pif.EXMEM_en     = exmem_en;
  assign pif.IFID_flush   = ifid_flush;
  assign pif.IDEX_flush   = idex_flush;
  assign pif.MEMWB_bubble = memwb_bubble;
  assign pif.mem_err      = err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // ERR freezes the PC too, but that is a failure, not a stall.
  assign stall_cnt_d = (!pc_write && state_q != ERR) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  assign flush_cnt_d = (ifid_flush || idex_flush) ? flush_cnt_q + 32'd1 : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pif.stall_cnt = stall_cnt_q;
  assign pif.flush_cnt = flush_cnt_q;
`else
  assign pif.stall_cnt = 32'd0;
  assign pif.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model

module tb_pipe_ctrl;

  localparam int TO = 4;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if pif ();

  pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pif   (pif)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: plain flags and counts.
  bit          m_in_wait;
  bit          m_dead;
  int          m_waited;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // {PCWrite, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_flush, MEMWB_bubble, dmem_req}
  function automatic logic [7:0] dut_vec();
    return {pif.PCWrite, pif.IFID_en, pif.IDEX_en, pif.EXMEM_en,
            pif.IFID_flush, pif.IDEX_flush, pif.MEMWB_bubble, pif.dmem_req};
  endfunction

  function automatic logic [7:0] model_out();
    bit hz;
    bit rq;
    hz = pif.MemRead_ex && (pif.rdAddr_ex != 0) &&
         ((pif.rs1Used_id && pif.rs1Addr_id == pif.rdAddr_ex) ||
          (pif.rs2Used_id && pif.rs2Addr_id == pif.rdAddr_ex));
    rq = pif.MemAccess_mem;
    if (m_dead)                                  return 8'b0000_0010;
    if (pif.MemAccess_mem && !pif.dmem_ready)    return 8'b0000_0011;
    if (pif.BranchTaken_ex)                      return {7'b1111_110, rq};
    if (hz)                                      return {7'b0011_010, rq};
    return {7'b1111_000, rq};
  endfunction

  function automatic logic [31:0] perf(input logic [31:0] v);
    return PERF_ON ? v : 32'd0;
  endfunction

  task automatic model_reset();
    m_in_wait = 0;
    m_dead    = 0;
    m_waited  = 0;
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic model_step(input logic [7:0] o);
    bit stalled;
    if (m_dead) return;
    if (!o[7])       m_stalls  = m_stalls + 1;
    if (o[3] | o[2]) m_flushes = m_flushes + 1;
    stalled = pif.MemAccess_mem && !pif.dmem_ready;
    if (!stalled) begin
      m_in_wait = 0;
      m_waited  = 0;
    end else if (!m_in_wait) begin
      m_in_wait = 1;
      m_waited  = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) m_dead = 1;
    end
  endtask

  task automatic drive(input bit acc, input bit rdy, input bit br, input bit mr,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2);
    pif.MemAccess_mem  = acc;
    pif.dmem_ready     = rdy;
    pif.BranchTaken_ex = br;
    pif.MemRead_ex     = mr;
    pif.rdAddr_ex      = rd;
    pif.rs1Addr_id     = rs1;
    pif.rs2Addr_id     = rs2;
    pif.rs1Used_id     = u1;
    pif.rs2Used_id     = u2;
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle, advances one clock.
  task automatic tick(input string tag);
    logic [7:0] exp;
    #4;
    exp = model_out();
    chk({tag, "_ctl"}, {24'd0, dut_vec()}, {24'd0, exp});
    chk({tag, "_err"}, {31'd0, pif.mem_err}, {31'd0, m_dead});
    chk({tag, "_scnt"}, pif.stall_cnt, perf(m_stalls));
    chk({tag, "_fcnt"}, pif.flush_cnt, perf(m_flushes));
    model_step(exp);
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset takes effect asynchronously, checked before any edge.
  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_ctl"}, {24'd0, dut_vec()}, {24'd0, 8'b1111_0000});
    chk({tag, "_rst_err"}, {31'd0, pif.mem_err}, 32'd0);
    chk({tag, "_rst_scnt"}, pif.stall_cnt, 32'd0);
    chk({tag, "_rst_fcnt"}, pif.flush_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rdy_pct;
    bit acc;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset("init");

    // Load-use on rs1, then x0 destination which must not stall.
    drive(0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 0); tick("lu");
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0); tick("lu_after");
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd1, 1, 0); tick("lu_x0");
    // rs2 match but rs2 not used, then used.
    drive(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0); tick("lu_rs2_unused");
    drive(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1); tick("lu_rs2");
    // Branch beats load-use.
    drive(0, 0, 1, 1, 5'd5, 5'd5, 5'd1, 1, 0); tick("br_lu");

    // Memory wait: 3 stalled cycles then ready, with a load-use behind it.
    repeat (3) begin drive(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0); tick("mw_stall"); end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick("mw_done");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("mw_idle");

    // Timeout: ready never comes.
    do_reset("to");
    repeat (TO + 3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("to_stall"); end
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0); tick("to_dead");
    chk("to_err_sticky", {31'd0, pif.mem_err}, 32'd1);

    // Ready arrives on exactly the TO-th wait cycle: no error.
    do_reset("tob");
    repeat (TO) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("tob_stall"); end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick("tob_ready");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("tob_idle");
    chk("tob_no_err", {31'd0, pif.mem_err}, 32'd0);

    // Reset in the middle of a wait, then a full-length wait must still be tolerated.
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("rw_a");
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("rw_b");
    do_reset("rw");
    repeat (TO) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("rw_stall"); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick("rw_idle");
    chk("rw_no_err", {31'd0, pif.mem_err}, 32'd0);

    // Perf: 3 stall cycles plus one branch.
    do_reset("pf");
    repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick("pf_stall"); end
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0); tick("pf_rel");
    drive(0, 0, 1, 0, 0, 0, 0, 0, 0); tick("pf_br");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pf_stall_cnt", pif.stall_cnt, PERF_ON ? 32'd3 : 32'd0);
    chk("pf_flush_cnt", pif.flush_cnt, PERF_ON ? 32'd1 : 32'd0);

    // Randomised phases with varying memory latency.
    rdy_pct = 60;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 15;
          1:       rdy_pct = 60;
          default: rdy_pct = 95;
        endcase
      end
      if ((m_dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset("rnd");
      end else begin
        acc = m_in_wait ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 1);
        drive(acc, $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 5) == 0,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        tick("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall/flush sequencer for the five-stage RISC-V core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. Three conditions feed its decisions: data-memory wait states (req/ready handshake), load-use hazards and taken branches. It sits beside the pipeline registers and owns all freeze and bubble decisions; it carries no datapath.

## Interface
Parameters:
- MEM_TIMEOUT, 15: number of consecutive MEM_WAIT cycles before the block enters the fatal error state.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MemRead_ex  input  1  instruction in EX is a load.
- rdAddr_ex  input  5  destination register of the instruction in EX.
- rs1Addr_id, rs2Addr_id  input  5 each  source registers of the instruction in ID.
- rs1Used_id, rs2Used_id  input  1 each  the instruction in ID actually reads rs1 / rs2.
- BranchTaken_ex  input  1  branch or jump resolved taken in EX.
- MemAccess_mem  input  1  valid load/store in MEM.
- dmem_ready  input  1  data memory completes the access this cycle.
- dmem_req  output  1  access request to data memory.
- PCWrite  output  1  PC update enable.
- IFID_en, IDEX_en, EXMEM_en  output  1 each  register load enables.
- IFID_flush, IDEX_flush  output  1 each  load a bubble (all control bits zero).
- MEMWB_bubble  output  1  force WB_wb to 2'b00 on the next edge.
- mem_err  output  1  sticky timeout error.
- stall_cnt, flush_cnt  output  32 each  performance counters (see Configuration).

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN, wait counter 0, mem_err 0.
- dmem_req = MemAccess_mem while in RUN or MEM_WAIT; it is 0 in ERR.
- Memory stall:
  - Condition: MemAccess_mem=1 and dmem_ready=0, in RUN or MEM_WAIT.
  - Response: PCWrite, IFID_en, IDEX_en and EXMEM_en all 0; MEMWB_bubble=1.
  - State: RUN moves to MEM_WAIT.
- MEM_WAIT:
  - The wait counter increments each stalled cycle.
  - dmem_ready=1 releases the freeze in that same cycle. MEMWB_bubble=0 so the real result enters MEM/WB. The next state is RUN and the counter clears.
  - If the counter equals MEM_TIMEOUT while still stalled, the next state is ERR.
- Branch (RUN, no memory stall): BranchTaken_ex=1 gives IFID_flush=1 and IDEX_flush=1, with PCWrite=1 so the PC takes the redirect.
- Load-use (RUN, no memory stall, no taken branch):
  - Condition: MemRead_ex=1, rdAddr_ex≠0, and either (rs1Used_id and rs1Addr_id=rdAddr_ex) or (rs2Used_id and rs2Addr_id=rdAddr_ex).
  - Response: PCWrite=0, IFID_en=0, IDEX_flush=1, for one cycle.
- Priority: memory stall > branch > load-use. Lower-priority conditions are ignored while a higher one holds and are re-evaluated once the pipeline advances.
- ERR:
  - All enables 0, flushes 0, MEMWB_bubble=1, mem_err=1.
  - Left only by rst_n.
- Otherwise (RUN, no condition active): all enables 1, flushes 0, MEMWB_bubble=0.

## Timing
- All control outputs are combinational (Mealy) from state and current inputs, so a stall takes effect in the same cycle the condition appears. Latency is zero.
- State, counter, mem_err and performance counters are registered.
- Reset values while rst_n=0, with all inputs 0: PCWrite=1, IFID_en=IDEX_en=EXMEM_en=1, IFID_flush=IDEX_flush=0, MEMWB_bubble=0, dmem_req=0, mem_err=0, stall_cnt=flush_cnt=0.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN immediately (asynchronous). The in-flight access is abandoned.
- Wait counter width is $clog2(MEM_TIMEOUT+1). It saturates and never wraps.
- Timeout boundary: MEM_TIMEOUT=15 means the 15th stalled cycle in MEM_WAIT transitions to ERR. dmem_ready arriving on that same cycle wins: the block completes and returns to RUN, with no error.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments every cycle in which PCWrite=0 and the state is not ERR.
  - flush_cnt increments every cycle with IFID_flush or IDEX_flush set.
  - Both are 32-bit, wrap modulo 2^32 and clear on reset.
- PIPE_CTRL_PERF_EN undefined: both outputs are constant 0 and no counter flops are built.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state encoding (RUN=2'd0, MEM_WAIT=2'd1, ERR=2'd2);
  - the WB bubble value 2'b00;
  - the default MEM_TIMEOUT.
- One sub-module, pipe_hazard_detect: purely combinational load-use comparator producing a single hazard bit. The FSM, priority logic and counters stay in pipe_ctrl.

## Test plan
- Load-use: MemRead_ex=1, rdAddr_ex=5, rs1Used_id=1, rs1Addr_id=5 for one cycle -> PCWrite=0, IFID_en=0, IDEX_flush=1 that cycle, then all normal. Repeat with rdAddr_ex=0 -> no stall.
- Branch plus load-use: BranchTaken_ex=1 together with the above hazard -> IFID_flush=IDEX_flush=1, PCWrite=1.
- Memory wait: MemAccess_mem=1 with dmem_ready low for 3 cycles, then high:
  - cycles 0-2: all enables 0, MEMWB_bubble=1, dmem_req=1;
  - cycle 3: all enables 1, bubble 0;
  - state sequence RUN→MEM_WAIT→RUN.
- Timeout: MEM_TIMEOUT=4 and dmem_ready held low -> mem_err=1 after the 4th MEM_WAIT cycle and stays set. Separately, dmem_ready rising exactly on the 4th cycle -> no error.
- Reset mid-wait: assert rst_n=0 during MEM_WAIT -> outputs take reset values immediately; after release the state is RUN.
- PERF (macro defined): 3 stall cycles plus 1 branch -> stall_cnt=3, flush_cnt=1.
